// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage vector pipeline: stalls, flushes, EX forwarding and memory-wait timeout.
// Optional performance counters are compiled in when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int RA_W        = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] RA1D,
    input  logic [RA_W-1:0] RA2D,
    input  logic [RA_W-1:0] RA1E,
    input  logic [RA_W-1:0] RA2E,
    input  logic [RA_W-1:0] WA3E,
    input  logic [RA_W-1:0] WA3M,
    input  logic [RA_W-1:0] WA3W,
    input  logic            RegWriteE,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    input  logic            MemtoRegE,
    input  logic            BranchTakenE,
    input  logic            MemBusyM,
    output logic            StallF,
    output logic            StallD,
    output logic            StallE,
    output logic            StallM,
    output logic            FlushD,
    output logic            FlushE,
    output logic            FlushW,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic            MemTimeout,
    output logic [1:0]      hazard_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic [CNT_W-1:0] LdUseCnt
`endif
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   wait_cnt, wait_cnt_n;
    logic            timeout_n;
    logic            ld_haz;

    assign hazard_state = state;
    assign ld_haz = MemtoRegE && RegWriteE && ((WA3E == RA1D) || (WA3E == RA2D));

    // Operand forwarding: the younger result in MEM wins over WB.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!reset) begin
            if (RegWriteM && (WA3M == RA1E))      ForwardAE = 2'b10;
            else if (RegWriteW && (WA3W == RA1E)) ForwardAE = 2'b01;
            if (RegWriteM && (WA3M == RA2E))      ForwardBE = 2'b10;
            else if (RegWriteW && (WA3W == RA2E)) ForwardBE = 2'b01;
        end
    end

    always_comb begin
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushW     = 1'b0;
        state_n    = state;
        wait_cnt_n = wait_cnt;
        timeout_n  = MemTimeout;

        if (!reset) begin
            if (MemBusyM) begin
                // Freeze the front, bubble WB so the held MEM instr is not written back twice.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (BranchTakenE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (ld_haz) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end

        unique case (state)
            RUN: begin
                if (MemBusyM) begin
                    state_n    = MEMWAIT;
                    wait_cnt_n = CW'(1);
                end else if (!BranchTakenE && ld_haz) begin
                    state_n = LDSTALL;
                end
            end
            LDSTALL: begin
                if (MemBusyM) begin
                    state_n    = MEMWAIT;
                    wait_cnt_n = CW'(1);
                end else begin
                    state_n = RUN;
                end
            end
            MEMWAIT: begin
                if (MemBusyM) begin
                    if (wait_cnt != TO_VAL) wait_cnt_n = wait_cnt + CW'(1);
                end else begin
                    state_n = RUN;
                end
            end
            default: state_n = RUN;
        endcase

        // The entry cycle counts as the first busy cycle of the wait.
        if ((state_n == MEMWAIT) && (wait_cnt_n >= TO_VAL)) timeout_n = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            wait_cnt   <= '0;
            MemTimeout <= 1'b0;
        end else begin
            state      <= state_n;
            wait_cnt   <= wait_cnt_n;
            MemTimeout <= timeout_n;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCnt <= '0;
            FlushCnt <= '0;
            LdUseCnt <= '0;
        end else begin
            if (StallF && (StallCnt != '1)) StallCnt <= StallCnt + 1'b1;
            if (FlushE && BranchTakenE && (FlushCnt != '1)) FlushCnt <= FlushCnt + 1'b1;
            if ((state == RUN) && (state_n == LDSTALL) && (LdUseCnt != '1))
                LdUseCnt <= LdUseCnt + 1'b1;
        end
    end
`else
    // CNT_W only sizes the optional counters.
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule
